// File: rtl/mrv1_tw_barrier_ctl.sv
// Barrier scheduler: records which warps have arrived at each barrier, holds them
// stalled, and releases the whole group once the requested warp count is reached.
module mrv1_tw_barrier_ctl #(
    parameter  int NUM_TW_P            = 8,
    parameter  int num_barriers_p      = 8,
    localparam int wid_width_lp        = $clog2(NUM_TW_P),
    localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           bar_req_i,
    output logic                           bar_rdy_o,
    input  logic [wid_width_lp-1:0]        bar_wid_i,
    input  logic [barrier_id_width_lp-1:0] bar_id_i,
    input  logic [wid_width_lp-1:0]        bar_size_m1_i,
    input  logic                           kill_vld_i,
    input  logic [NUM_TW_P-1:0]            kill_wmask_i,
    output logic                           release_vld_o,
    output logic [barrier_id_width_lp-1:0] release_id_o,
    output logic [NUM_TW_P-1:0]            release_wmask_o,
    output logic [NUM_TW_P-1:0]            stall_wmask_o,
    output logic                           err_o
);

    localparam logic [wid_width_lp:0] CNT_ONE_LP = {{wid_width_lp{1'b0}}, 1'b1};
    localparam logic [NUM_TW_P-1:0]   WID_ONE_LP = {{(NUM_TW_P-1){1'b0}}, 1'b1};

    // One extra bit so a barrier spanning every warp still fits the count.
    function automatic logic [wid_width_lp:0] popcount(input logic [NUM_TW_P-1:0] mask);
        logic [wid_width_lp:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_TW_P; i++) begin
            cnt = cnt + {{wid_width_lp{1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

    logic [NUM_TW_P-1:0]            wait_mask_r [num_barriers_p];
    logic [wid_width_lp-1:0]        size_m1_r   [num_barriers_p];
    logic [NUM_TW_P-1:0]            wait_mask_s [num_barriers_p];
    logic [wid_width_lp-1:0]        size_m1_s   [num_barriers_p];
    logic                           rdy_r;
    logic                           release_vld_r, release_vld_s;
    logic [barrier_id_width_lp-1:0] release_id_r, release_id_s;
    logic [NUM_TW_P-1:0]            release_wmask_r, release_wmask_s;
    logic [NUM_TW_P-1:0]            stall_wmask_r, stall_wmask_s;
    logic                           err_r, err_s;
    logic [NUM_TW_P-1:0]            kill_s, wid_bit_s, cur_mask_s;
    logic                           cur_active_s;
    logic [wid_width_lp-1:0]        eff_size_s;
    logic [wid_width_lp:0]          arrive_cnt_s;

    // Arrival/kill evaluation and next-state computation for all barrier entries.
    always_comb begin
        wait_mask_s     = wait_mask_r;
        size_m1_s       = size_m1_r;
        release_vld_s   = 1'b0;
        release_id_s    = release_id_r;
        release_wmask_s = release_wmask_r;
        err_s           = 1'b0;
        kill_s          = kill_vld_i ? kill_wmask_i : '0;
        wid_bit_s       = WID_ONE_LP << bar_wid_i;
        cur_mask_s      = wait_mask_r[bar_id_i];
        cur_active_s    = |cur_mask_s;
        // An active barrier keeps its original size; only a fresh one latches the request's.
        eff_size_s      = cur_active_s ? size_m1_r[bar_id_i] : bar_size_m1_i;
        arrive_cnt_s    = popcount(cur_mask_s) + CNT_ONE_LP;

        for (int b = 0; b < num_barriers_p; b++) begin
            wait_mask_s[b] = wait_mask_r[b] & ~kill_s;
        end

        if (bar_req_i && rdy_r) begin
            if ((wid_bit_s & kill_s) != '0) begin
                err_s = 1'b0;
            end else if ((wid_bit_s & stall_wmask_r) != '0) begin
                err_s = 1'b1;
            end else begin
                err_s = cur_active_s && (bar_size_m1_i != size_m1_r[bar_id_i]);
                if (arrive_cnt_s == ({1'b0, eff_size_s} + CNT_ONE_LP)) begin
                    release_vld_s         = 1'b1;
                    release_id_s          = bar_id_i;
                    release_wmask_s       = cur_mask_s | wid_bit_s;
                    wait_mask_s[bar_id_i] = '0;
                    size_m1_s[bar_id_i]   = '0;
                end else begin
                    wait_mask_s[bar_id_i] = wait_mask_s[bar_id_i] | wid_bit_s;
                    size_m1_s[bar_id_i]   = eff_size_s;
                end
            end
        end else begin
            err_s = 1'b0;
        end

        stall_wmask_s = '0;
        for (int b = 0; b < num_barriers_p; b++) begin
            stall_wmask_s = stall_wmask_s | wait_mask_s[b];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < num_barriers_p; b++) begin
                wait_mask_r[b] <= '0;
                size_m1_r[b]   <= '0;
            end
            rdy_r           <= 1'b0;
            release_vld_r   <= 1'b0;
            release_id_r    <= '0;
            release_wmask_r <= '0;
            stall_wmask_r   <= '0;
            err_r           <= 1'b0;
        end else begin
            wait_mask_r     <= wait_mask_s;
            size_m1_r       <= size_m1_s;
            rdy_r           <= 1'b1;
            release_vld_r   <= release_vld_s;
            release_id_r    <= release_id_s;
            release_wmask_r <= release_wmask_s;
            stall_wmask_r   <= stall_wmask_s;
            err_r           <= err_s;
        end
    end

    assign bar_rdy_o       = rdy_r;
    assign release_vld_o   = release_vld_r;
    assign release_id_o    = release_id_r;
    assign release_wmask_o = release_wmask_r;
    assign stall_wmask_o   = stall_wmask_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_mrv1_tw_barrier_ctl.sv
// Bench for mrv1_tw_barrier_ctl: directed scenarios plus random arrivals/kills,
// compared against a queue-per-barrier reference model.
module tb_mrv1_tw_barrier_ctl;

    localparam int NT = 8;
    localparam int NB = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       bar_req_i = 1'b0;
    logic       bar_rdy_o;
    logic [2:0] bar_wid_i = 3'd0;
    logic [2:0] bar_id_i = 3'd0;
    logic [2:0] bar_size_m1_i = 3'd0;
    logic       kill_vld_i = 1'b0;
    logic [7:0] kill_wmask_i = 8'h00;
    logic       release_vld_o;
    logic [2:0] release_id_o;
    logic [7:0] release_wmask_o;
    logic [7:0] stall_wmask_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: list of arrived warp ids per barrier plus the governing size.
    int         wq [NB][$];
    int         msz [NB];
    logic       exp_vld, exp_err;
    logic [2:0] exp_id;
    logic [7:0] exp_mask, exp_stall;

    mrv1_tw_barrier_ctl #(.NUM_TW_P(NT), .num_barriers_p(NB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bar_req_i(bar_req_i), .bar_rdy_o(bar_rdy_o),
        .bar_wid_i(bar_wid_i), .bar_id_i(bar_id_i), .bar_size_m1_i(bar_size_m1_i),
        .kill_vld_i(kill_vld_i), .kill_wmask_i(kill_wmask_i),
        .release_vld_o(release_vld_o), .release_id_o(release_id_o),
        .release_wmask_o(release_wmask_o), .stall_wmask_o(stall_wmask_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] qmask(input int b);
        logic [7:0] m;
        m = 8'h00;
        foreach (wq[b][i]) m[wq[b][i]] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] all_waiting();
        logic [7:0] m;
        m = 8'h00;
        for (int b = 0; b < NB; b++) m = m | qmask(b);
        return m;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            wq[b].delete();
            msz[b] = 0;
        end
        exp_vld = 1'b0; exp_err = 1'b0; exp_id = 3'd0; exp_mask = 8'h00; exp_stall = 8'h00;
    endtask

    task automatic model_step(input logic req, input int w, input int b, input int s,
                              input logic kv, input logic [7:0] km);
        int n;
        int need;
        int keep [$];
        logic [7:0] waiting;
        waiting = all_waiting();
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (req && !(kv && km[w])) begin
            if (waiting[w]) begin
                exp_err = 1'b1;
            end else begin
                n = wq[b].size();
                if (n > 0 && s != msz[b]) exp_err = 1'b1;
                need = (n > 0) ? msz[b] + 1 : s + 1;
                if (n + 1 == need) begin
                    exp_vld  = 1'b1;
                    exp_id   = 3'(b);
                    exp_mask = qmask(b) | (8'h01 << w);
                    wq[b].delete();
                end else begin
                    if (n == 0) msz[b] = s;
                    wq[b].push_back(w);
                end
            end
        end
        if (kv) begin
            for (int bb = 0; bb < NB; bb++) begin
                keep.delete();
                foreach (wq[bb][i]) if (!km[wq[bb][i]]) keep.push_back(wq[bb][i]);
                wq[bb] = keep;
            end
        end
        exp_stall = all_waiting();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_rdy"},   32'(bar_rdy_o), 32'd1);
        chk({tag, "_vld"},   32'(release_vld_o), 32'(exp_vld));
        chk({tag, "_err"},   32'(err_o), 32'(exp_err));
        chk({tag, "_stall"}, 32'(stall_wmask_o), 32'(exp_stall));
        chk({tag, "_id"},    32'(release_id_o), 32'(exp_id));
        chk({tag, "_mask"},  32'(release_wmask_o), 32'(exp_mask));
    endtask

    task automatic step(input string tag, input logic req, input int w, input int b,
                        input int s, input logic kv, input logic [7:0] km);
        bar_req_i     = req;
        bar_wid_i     = 3'(w);
        bar_id_i      = 3'(b);
        bar_size_m1_i = 3'(s);
        kill_vld_i    = kv;
        kill_wmask_i  = km;
        model_step(req, w, b, s, kv, km);
        @(posedge clk_i);
        #1;
        check_outputs(tag);
        bar_req_i  = 1'b0;
        kill_vld_i = 1'b0;
    endtask

    task automatic arrive(input string tag, input int w, input int b, input int s);
        step(tag, 1'b1, w, b, s, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input int cycles);
        rst_i     = 1'b1;
        bar_req_i = 1'b0;
        kill_vld_i = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            chk("rst_rdy",   32'(bar_rdy_o), 32'd0);
            chk("rst_vld",   32'(release_vld_o), 32'd0);
            chk("rst_id",    32'(release_id_o), 32'd0);
            chk("rst_mask",  32'(release_wmask_o), 32'd0);
            chk("rst_stall", 32'(stall_wmask_o), 32'd0);
            chk("rst_err",   32'(err_o), 32'd0);
        end
        model_reset();
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_outputs("post_rst");
    endtask

    initial begin
        int r;
        model_reset();
        do_reset(3);

        // Three-warp barrier completes on the third arrival.
        arrive("t1_w0", 0, 3, 2);
        chk("t1_stall0", 32'(stall_wmask_o), 32'h01);
        arrive("t1_w1", 1, 3, 2);
        chk("t1_stall1", 32'(stall_wmask_o), 32'h03);
        arrive("t1_w2", 2, 3, 2);
        chk("t1_rel", 32'(release_vld_o), 32'd1);
        chk("t1_relid", 32'(release_id_o), 32'd3);
        chk("t1_relmask", 32'(release_wmask_o), 32'h07);
        step("t1_idle", 1'b0, 0, 0, 0, 1'b0, 8'h00);
        chk("t1_pulse", 32'(release_vld_o), 32'd0);
        chk("t1_hold", 32'(release_wmask_o), 32'h07);

        // Single-warp barrier releases immediately.
        arrive("t2_w5", 5, 0, 0);
        chk("t2_relmask", 32'(release_wmask_o), 32'h20);
        chk("t2_stall", 32'(stall_wmask_o), 32'h00);

        // Re-arrival of a stalled warp is an error and leaves barrier 4 untouched.
        arrive("t3_w1", 1, 2, 1);
        arrive("t3_dup", 1, 4, 1);
        chk("t3_err", 32'(err_o), 32'd1);
        arrive("t3_w3", 3, 2, 1);
        chk("t3_relmask", 32'(release_wmask_o), 32'h0A);
        chk("t3_errpulse", 32'(err_o), 32'd0);

        // Size mismatch: stored size wins, arrival still recorded.
        arrive("t4_w0", 0, 1, 3);
        arrive("t4_w2", 2, 1, 1);
        chk("t4_err", 32'(err_o), 32'd1);
        chk("t4_norel", 32'(release_vld_o), 32'd0);
        chk("t4_stall", 32'(stall_wmask_o), 32'h05);
        step("t4_kill", 1'b0, 0, 0, 0, 1'b1, 8'h05);

        // Kill removes a waiter without releasing; the original size still governs.
        arrive("t5_w0", 0, 6, 2);
        arrive("t5_w1", 1, 6, 2);
        step("t5_kill", 1'b0, 0, 0, 0, 1'b1, 8'h02);
        chk("t5_stall", 32'(stall_wmask_o), 32'h01);
        arrive("t5_w4", 4, 6, 2);
        arrive("t5_w7", 7, 6, 2);
        chk("t5_relmask", 32'(release_wmask_o), 32'h91);

        // Arrival of a warp killed in the same cycle is silently dropped.
        step("t5b_killarr", 1'b1, 3, 0, 1, 1'b1, 8'h08);
        chk("t5b_err", 32'(err_o), 32'd0);

        // Mid-operation reset discards waiters without a release.
        arrive("t6_w0", 0, 5, 3);
        arrive("t6_w1", 1, 5, 3);
        arrive("t6_w2", 2, 5, 3);
        do_reset(1);
        arrive("t6_w6", 6, 5, 0);
        chk("t6_relmask", 32'(release_wmask_o), 32'h40);

        // Randomized arrivals and kills against the reference model.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                step("rnd_arr", 1'b1, $urandom_range(0, 7), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 2), 1'b0, 8'h00);
            end else if (r < 8) begin
                step("rnd_kill", 1'b0, 0, 0, 0, 1'b1, 8'($urandom & $urandom));
            end else if (r < 9) begin
                step("rnd_both", 1'b1, $urandom_range(0, 7), $urandom_range(4, 7),
                     $urandom_range(1, 3), 1'b1, 8'($urandom & $urandom & $urandom));
            end else begin
                step("rnd_idle", 1'b0, 0, 0, 0, 1'b0, 8'h00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
